dual_issue_scheduler: RTL and testbench



---
 rtl/dual_issue_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_dual_issue_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_scheduler.sv
// Dual-issue pairing controller: issues an older/younger instruction pair together
// when legal, otherwise issues A now and the held B in lane A on the next cycle.
module dual_issue_scheduler #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc_a,
    input  logic [31:0]      in_pc_b,
    input  logic [31:0]      in_instr_a,
    input  logic [31:0]      in_instr_b,
    input  logic             in_vld_a,
    input  logic             in_vld_b,
    input  logic             stall,
    input  logic             flush,
    output logic [31:0]      out_pc_a,
    output logic [31:0]      out_pc_b,
    output logic [31:0]      out_instr_a,
    output logic [31:0]      out_instr_b,
    output logic             out_vld_a,
    output logic             out_vld_b,
    output logic [CNT_W-1:0] split_cnt,
    output logic             dbg_state_o
);

    // Upstream handshake: a pair transfers on a cycle where in_valid && in_ready.
    // in_ready depends only on rst, flush, stall and the registered state.

    typedef enum logic {
        PAIR   = 1'b0,
        HOLD_B = 1'b1
    } state_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
            OP_OP, OP_OPIMM, OP_LOAD: writes_rd = 1'b1;
            default:                  writes_rd = 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs1(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL: reads_rs1 = 1'b0;
            default:                  reads_rs1 = 1'b1;
        endcase
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        case (op)
            OP_OP, OP_STORE, OP_BRANCH: reads_rs2 = 1'b1;
            default:                    reads_rs2 = 1'b0;
        endcase
    endfunction

    function automatic logic is_mem(input logic [6:0] op);
        is_mem = (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic is_ctrl(input logic [6:0] op);
        is_ctrl = (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

    state_e             state_q, state_d;
    logic [31:0]        out_pc_a_q, out_pc_a_d;
    logic [31:0]        out_pc_b_q, out_pc_b_d;
    logic [31:0]        out_instr_a_q, out_instr_a_d;
    logic [31:0]        out_instr_b_q, out_instr_b_d;
    logic               out_vld_a_q, out_vld_a_d;
    logic               out_vld_b_q, out_vld_b_d;
    logic [31:0]        held_pc_q, held_pc_d;
    logic [31:0]        held_instr_q, held_instr_d;
    logic [CNT_W-1:0]   split_cnt_q, split_cnt_d;

    logic [6:0] op_a, op_b;
    logic [4:0] rd_a, rs1_b, rs2_b;
    logic       raw_hazard, mem_conflict, ctrl_a, split_req, accept;

    assign op_a  = in_instr_a[6:0];
    assign op_b  = in_instr_b[6:0];
    assign rd_a  = in_instr_a[11:7];
    assign rs1_b = in_instr_b[19:15];
    assign rs2_b = in_instr_b[24:20];

    assign raw_hazard   = writes_rd(op_a) && (rd_a != 5'd0) &&
                          ((reads_rs1(op_b) && (rs1_b == rd_a)) ||
                           (reads_rs2(op_b) && (rs2_b == rd_a)));
    assign mem_conflict = is_mem(op_a) && is_mem(op_b);
    assign ctrl_a       = is_ctrl(op_a);
    assign split_req    = in_vld_a && in_vld_b && (raw_hazard || mem_conflict || ctrl_a);

    assign in_ready = !rst && !flush && !stall && (state_q == PAIR);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        out_pc_a_d    = out_pc_a_q;
        out_pc_b_d    = out_pc_b_q;
        out_instr_a_d = out_instr_a_q;
        out_instr_b_d = out_instr_b_q;
        out_vld_a_d   = out_vld_a_q;
        out_vld_b_d   = out_vld_b_q;
        held_pc_d     = held_pc_q;
        held_instr_d  = held_instr_q;
        split_cnt_d   = split_cnt_q;

        if (flush) begin
            // Redirect wins over stall: kill issued slots and the pending B.
            out_vld_a_d  = 1'b0;
            out_vld_b_d  = 1'b0;
            held_pc_d    = '0;
            held_instr_d = '0;
            state_d      = PAIR;
        end else if (!stall) begin
            case (state_q)
                PAIR: begin
                    if (accept && split_req) begin
                        out_pc_a_d    = in_pc_a;
                        out_instr_a_d = in_instr_a;
                        out_vld_a_d   = 1'b1;
                        out_vld_b_d   = 1'b0;
                        held_pc_d     = in_pc_b;
                        held_instr_d  = in_instr_b;
                        state_d       = HOLD_B;
                        if (!(&split_cnt_q)) begin
                            split_cnt_d = split_cnt_q + CNT_W'(1);
                        end
                    end else if (accept && !in_vld_a && in_vld_b) begin
                        // Lone younger instruction is promoted to the older lane.
                        out_pc_a_d    = in_pc_b;
                        out_instr_a_d = in_instr_b;
                        out_vld_a_d   = 1'b1;
                        out_vld_b_d   = 1'b0;
                    end else if (accept) begin
                        out_pc_a_d    = in_pc_a;
                        out_instr_a_d = in_instr_a;
                        out_pc_b_d    = in_pc_b;
                        out_instr_b_d = in_instr_b;
                        out_vld_a_d   = in_vld_a;
                        out_vld_b_d   = in_vld_b;
                    end else begin
                        out_vld_a_d = 1'b0;
                        out_vld_b_d = 1'b0;
                    end
                end
                HOLD_B: begin
                    out_pc_a_d    = held_pc_q;
                    out_instr_a_d = held_instr_q;
                    out_vld_a_d   = 1'b1;
                    out_vld_b_d   = 1'b0;
                    state_d       = PAIR;
                end
                default: state_d = PAIR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= PAIR;
            out_pc_a_q    <= '0;
            out_pc_b_q    <= '0;
            out_instr_a_q <= '0;
            out_instr_b_q <= '0;
            out_vld_a_q   <= 1'b0;
            out_vld_b_q   <= 1'b0;
            held_pc_q     <= '0;
            held_instr_q  <= '0;
            split_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            out_pc_a_q    <= out_pc_a_d;
            out_pc_b_q    <= out_pc_b_d;
            out_instr_a_q <= out_instr_a_d;
            out_instr_b_q <= out_instr_b_d;
            out_vld_a_q   <= out_vld_a_d;
            out_vld_b_q   <= out_vld_b_d;
            held_pc_q     <= held_pc_d;
            held_instr_q  <= held_instr_d;
            split_cnt_q   <= split_cnt_d;
        end
    end

    assign out_pc_a    = out_pc_a_q;
    assign out_pc_b    = out_pc_b_q;
    assign out_instr_a = out_instr_a_q;
    assign out_instr_b = out_instr_b_q;
    assign out_vld_a   = out_vld_a_q;
    assign out_vld_b   = out_vld_b_q;
    assign split_cnt   = split_cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler: table of pairs plus hand-written
// stall, flush, reset and counter-saturation sequences.
module tb_dual_issue_scheduler;

    // Narrow counter so saturation is reachable in a short run.
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc_a, in_pc_b, in_instr_a, in_instr_b;
    logic             in_vld_a, in_vld_b;
    logic             stall, flush;
    logic [31:0]      out_pc_a, out_pc_b, out_instr_a, out_instr_b;
    logic             out_vld_a, out_vld_b;
    logic [CNT_W-1:0] split_cnt;
    logic             dbg_state_o;

    int checks   = 0;
    int failures = 0;
    logic [CNT_W-1:0] exp_cnt;

    dual_issue_scheduler #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc_a(in_pc_a), .in_pc_b(in_pc_b),
        .in_instr_a(in_instr_a), .in_instr_b(in_instr_b),
        .in_vld_a(in_vld_a), .in_vld_b(in_vld_b),
        .stall(stall), .flush(flush),
        .out_pc_a(out_pc_a), .out_pc_b(out_pc_b),
        .out_instr_a(out_instr_a), .out_instr_b(out_instr_b),
        .out_vld_a(out_vld_a), .out_vld_b(out_vld_b),
        .split_cnt(split_cnt), .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        va, vb;
        logic [31:0] ia, ib;
        logic        exp_va, exp_vb;
        logic        exp_b_in_a;
        logic        exp_split;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_pair(input logic va, input logic vb, input logic [31:0] ia,
                              input logic [31:0] ib, input logic [31:0] pa);
        in_valid   = 1'b1;
        in_vld_a   = va;
        in_vld_b   = vb;
        in_instr_a = ia;
        in_instr_b = ib;
        in_pc_a    = pa;
        in_pc_b    = pa + 32'd4;
    endtask

    task automatic bump_cnt();
        if (exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
    endtask

    initial begin
        logic [31:0] pa;

        //             va   vb   instr A        instr B        eva  evb  BinA split
        vecs[0]  = '{1'b1, 1'b1, 32'h002082B3, 32'h004183B3, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 32'h002082B3, 32'h40328333, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 32'h0000A283, 32'h00412303, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 32'h00108013, 32'h000003B3, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 32'h00208063, 32'h004183B3, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 32'h008000EF, 32'h004183B3, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 32'h002082B3, 32'h004183B3, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h002082B3, 32'h40328333, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 32'h002082B3, 32'h005183B3, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 32'h002082B3, 32'h00028337, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 32'h002082B3, 32'h0050A023, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 32'h00008067, 32'h004183B3, 1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        in_vld_a = 1'b0; in_vld_b = 1'b0;
        in_instr_a = '0; in_instr_b = '0; in_pc_a = '0; in_pc_b = '0;
        exp_cnt = '0;
        step();
        step();

        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_vld_a", 32'(out_vld_a), 32'd0);
        chk("rst_vld_b", 32'(out_vld_b), 32'd0);
        chk("rst_instr_a", out_instr_a, 32'd0);
        chk("rst_pc_b", out_pc_b, 32'd0);
        chk("rst_cnt", 32'(split_cnt), 32'd0);
        chk("rst_state", 32'(dbg_state_o), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            pa = 32'h1000 + 32'(i * 16);
            drive_pair(vecs[i].va, vecs[i].vb, vecs[i].ia, vecs[i].ib, pa);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'd1);
            step();
            in_valid = 1'b0;
            if (vecs[i].exp_split) bump_cnt();
            chk($sformatf("v%0d_vld_a", i), 32'(out_vld_a), 32'(vecs[i].exp_va));
            chk($sformatf("v%0d_vld_b", i), 32'(out_vld_b), 32'(vecs[i].exp_vb));
            chk($sformatf("v%0d_instr_a", i), out_instr_a,
                vecs[i].exp_b_in_a ? vecs[i].ib : vecs[i].ia);
            chk($sformatf("v%0d_pc_a", i), out_pc_a,
                vecs[i].exp_b_in_a ? pa + 32'd4 : pa);
            if (vecs[i].exp_vb) begin
                chk($sformatf("v%0d_instr_b", i), out_instr_b, vecs[i].ib);
                chk($sformatf("v%0d_pc_b", i), out_pc_b, pa + 32'd4);
            end
            chk($sformatf("v%0d_cnt", i), 32'(split_cnt), 32'(exp_cnt));
            if (vecs[i].exp_split) begin
                chk($sformatf("v%0d_hold_ready", i), 32'(in_ready), 32'd0);
                chk($sformatf("v%0d_hold_state", i), 32'(dbg_state_o), 32'd1);
                step();
                chk($sformatf("v%0d_b_vld_a", i), 32'(out_vld_a), 32'd1);
                chk($sformatf("v%0d_b_vld_b", i), 32'(out_vld_b), 32'd0);
                chk($sformatf("v%0d_b_instr", i), out_instr_a, vecs[i].ib);
                chk($sformatf("v%0d_b_pc", i), out_pc_a, pa + 32'd4);
                chk($sformatf("v%0d_b_ready", i), 32'(in_ready), 32'd1);
            end
        end

        // Bubble when nothing is offered.
        step();
        chk("bubble_vld_a", 32'(out_vld_a), 32'd0);
        chk("bubble_vld_b", 32'(out_vld_b), 32'd0);

        // Stall held for three cycles in HOLD_B.
        drive_pair(1'b1, 1'b1, 32'h002082B3, 32'h40328333, 32'h2000);
        step();
        in_valid = 1'b0;
        bump_cnt();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("stall%0d_vld_a", k), 32'(out_vld_a), 32'd1);
            chk($sformatf("stall%0d_vld_b", k), 32'(out_vld_b), 32'd0);
            chk($sformatf("stall%0d_instr_a", k), out_instr_a, 32'h002082B3);
            chk($sformatf("stall%0d_ready", k), 32'(in_ready), 32'd0);
            chk($sformatf("stall%0d_state", k), 32'(dbg_state_o), 32'd1);
        end
        stall = 1'b0;
        #1;
        chk("unstall_ready", 32'(in_ready), 32'd0);
        step();
        chk("unstall_b_instr", out_instr_a, 32'h40328333);
        chk("unstall_b_pc", out_pc_a, 32'h2004);
        chk("unstall_b_vld", 32'(out_vld_a), 32'd1);
        chk("unstall_cnt", 32'(split_cnt), 32'(exp_cnt));

        // Flush together with stall while B is held, with a pair offered.
        drive_pair(1'b1, 1'b1, 32'h0000A283, 32'h00412303, 32'h3000);
        step();
        bump_cnt();
        drive_pair(1'b1, 1'b1, 32'h002082B3, 32'h004183B3, 32'h3100);
        flush = 1'b1;
        stall = 1'b1;
        #1;
        chk("flush_ready", 32'(in_ready), 32'd0);
        step();
        chk("flush_vld_a", 32'(out_vld_a), 32'd0);
        chk("flush_vld_b", 32'(out_vld_b), 32'd0);
        chk("flush_state", 32'(dbg_state_o), 32'd0);
        chk("flush_cnt", 32'(split_cnt), 32'(exp_cnt));
        flush = 1'b0;
        stall = 1'b0;
        #1;
        chk("after_flush_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("after_flush_vld_a", 32'(out_vld_a), 32'd1);
        chk("after_flush_vld_b", 32'(out_vld_b), 32'd1);
        chk("after_flush_instr_a", out_instr_a, 32'h002082B3);
        chk("after_flush_pc_b", out_pc_b, 32'h3104);
        step();
        chk("held_b_gone", 32'(out_vld_a), 32'd0);

        // Reset asserted while B is held.
        drive_pair(1'b1, 1'b1, 32'h00208063, 32'h004183B3, 32'h4000);
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(in_ready), 32'd0);
        step();
        exp_cnt = '0;
        chk("midrst_vld_a", 32'(out_vld_a), 32'd0);
        chk("midrst_instr_a", out_instr_a, 32'd0);
        chk("midrst_pc_a", out_pc_a, 32'd0);
        chk("midrst_cnt", 32'(split_cnt), 32'd0);
        chk("midrst_state", 32'(dbg_state_o), 32'd0);
        rst = 1'b0;
        step();
        chk("midrst_no_b", 32'(out_vld_a), 32'd0);

        // Counter saturation.
        for (int k = 0; k < 20; k++) begin
            drive_pair(1'b1, 1'b1, 32'h0000A283, 32'h00412303, 32'h5000 + 32'(k * 8));
            step();
            in_valid = 1'b0;
            bump_cnt();
            step();
            if (k == 13) chk("sat_cnt_14", 32'(split_cnt), 32'd14);
        end
        chk("sat_cnt_max", 32'(split_cnt), 32'(CNT_MAX));
        chk("sat_cnt_model", 32'(split_cnt), 32'(exp_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
